// File: rtl/mac16_mult.sv
// mac16_mult: 16x16 multiply/accumulate slice with SB_MAC16-style configuration.
// Each 16-bit output half independently shows the 16x16 product, an 8x8 product,
// a combinational add/sub against C/D, or a CE-gated wrapping accumulator.
module mac16_mult #(
  parameter bit         A_SIGNED         = 1'b0,
  parameter bit         B_SIGNED         = 1'b0,
  parameter bit         A_REG            = 1'b0,
  parameter bit         B_REG            = 1'b0,
  parameter logic [1:0] TOPOUTPUT_SELECT = 2'b11,
  parameter logic [1:0] BOTOUTPUT_SELECT = 2'b11
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] C,
  input  logic [15:0] D,
  input  logic        ADDSUBTOP,
  input  logic        ADDSUBBOT,
  output logic [31:0] O
);

  localparam logic [1:0] SEL_ADDSUB = 2'b00;
  localparam logic [1:0] SEL_ACC    = 2'b01;
  localparam logic [1:0] SEL_MUL8   = 2'b10;

  logic [15:0] a_q, b_q;
  logic [15:0] am, bm;
  logic signed [31:0] a_ext, b_ext, p32;
  logic signed [15:0] at_ext, bt_ext, pt8;
  logic [15:0] pb8;
  logic [15:0] p_hi, p_lo;
  logic [15:0] add_t, add_b;
  logic [15:0] acc_t_q, acc_t_d, acc_b_q, acc_b_d;

  // Selects one output half's source; the mode is a parameter so this folds to a wire.
  function automatic logic [15:0] sel_half(input logic [1:0] mode, input logic [15:0] addsub,
                                           input logic [15:0] acc, input logic [15:0] p8,
                                           input logic [15:0] p16);
    logic [15:0] r;
    case (mode)
      SEL_ADDSUB: r = addsub;
      SEL_ACC:    r = acc;
      SEL_MUL8:   r = p8;
      default:    r = p16;
    endcase
    return r;
  endfunction

  // Optional CE-gated input registers ahead of the multiplier.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_q <= '0;
      b_q <= '0;
    end else if (CE) begin
      a_q <= A;
      b_q <= B;
    end
  end

  assign am = A_REG ? a_q : A;
  assign bm = B_REG ? b_q : B;

  // Products: operands extended per their signedness so an unsigned 0xFFFF stays 65535;
  // the low 32 bits of a 32x32 product equal the low 32 bits of the exact 17x17 product.
  always_comb begin
    a_ext  = {{16{A_SIGNED & am[15]}}, am};
    b_ext  = {{16{B_SIGNED & bm[15]}}, bm};
    p32    = a_ext * b_ext;
    at_ext = {{8{A_SIGNED & am[15]}}, am[15:8]};
    bt_ext = {{8{B_SIGNED & bm[15]}}, bm[15:8]};
    pt8    = at_ext * bt_ext;
    pb8    = {8'h00, am[7:0]} * {8'h00, bm[7:0]};
  end

  assign p_hi = p32[31:16];
  assign p_lo = p32[15:0];

  // Per-half add/sub paths, both combinational and accumulator next-state; halves never share a carry.
  always_comb begin
    add_t   = ADDSUBTOP ? (C - p_hi) : (C + p_hi);
    add_b   = ADDSUBBOT ? (D - p_lo) : (D + p_lo);
    acc_t_d = ADDSUBTOP ? (acc_t_q - p_hi) : (acc_t_q + p_hi);
    acc_b_d = ADDSUBBOT ? (acc_b_q - p_lo) : (acc_b_q + p_lo);
  end

  // Wrapping accumulators, advanced only on CE edges.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_t_q <= '0;
      acc_b_q <= '0;
    end else if (CE) begin
      acc_t_q <= acc_t_d;
      acc_b_q <= acc_b_d;
    end
  end

  assign O = {sel_half(TOPOUTPUT_SELECT, add_t, acc_t_q, pt8, p_hi),
              sel_half(BOTOUTPUT_SELECT, add_b, acc_b_q, pb8, p_lo)};

endmodule

// File: tb/tb_mac16_mult.sv
// Testbench for mac16_mult: several parameterisations share one input bus.
module tb_mac16_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [15:0] a, b, c, d;
  logic        ast, asb;
  logic [31:0] o1, o3, o4, o5, o6, o7, o8;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  // A signed, B unsigned (the audio-path setup)
  mac16_mult #(.A_SIGNED(1'b1)) u1 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .A(a), .B(b), .C(c), .D(d),
    .ADDSUBTOP(ast), .ADDSUBBOT(asb), .O(o1));
  // both signed
  mac16_mult #(.A_SIGNED(1'b1), .B_SIGNED(1'b1)) u3 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .A(a), .B(b), .C(c), .D(d),
    .ADDSUBTOP(ast), .ADDSUBBOT(asb), .O(o3));
  // both unsigned
  mac16_mult u4 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .A(a), .B(b), .C(c), .D(d),
    .ADDSUBTOP(ast), .ADDSUBBOT(asb), .O(o4));
  // registered inputs
  mac16_mult #(.A_REG(1'b1), .B_REG(1'b1)) u5 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .A(a), .B(b), .C(c), .D(d),
    .ADDSUBTOP(ast), .ADDSUBBOT(asb), .O(o5));
  // both halves accumulate, signed
  mac16_mult #(.A_SIGNED(1'b1), .B_SIGNED(1'b1), .TOPOUTPUT_SELECT(2'b01),
               .BOTOUTPUT_SELECT(2'b01)) u6 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .A(a), .B(b), .C(c), .D(d),
    .ADDSUBTOP(ast), .ADDSUBBOT(asb), .O(o6));
  // top add/sub, bottom 8x8, unsigned
  mac16_mult #(.TOPOUTPUT_SELECT(2'b00), .BOTOUTPUT_SELECT(2'b10)) u7 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .A(a), .B(b), .C(c), .D(d),
    .ADDSUBTOP(ast), .ADDSUBBOT(asb), .O(o7));
  // top signed 8x8, bottom add/sub
  mac16_mult #(.A_SIGNED(1'b1), .B_SIGNED(1'b1), .TOPOUTPUT_SELECT(2'b10),
               .BOTOUTPUT_SELECT(2'b00)) u8 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .A(a), .B(b), .C(c), .D(d),
    .ADDSUBTOP(ast), .ADDSUBBOT(asb), .O(o8));

  typedef struct {
    logic [15:0] a, b, c, d;
    logic        ast, asb;
    logic [31:0] e1, e3, e4, e7, e8;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic ce_edges(input int n);
    ce = 1'b1;
    repeat (n) @(negedge clk);
    ce = 1'b0;
  endtask

  initial begin
    //          a        b        c        d        ast   asb   u1 AsBu       u3 signed     u4 unsigned   u7 top+-/PB8  u8 PT8/bot+-
    vecs[0] = '{16'hC000, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'hE0000000, 32'h20000000, 32'h60000000, 32'h60000000, 32'h20000000};
    vecs[1] = '{16'h7FFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 32'h7FFE8001, 32'hFFFF8001, 32'h7FFE8001, 32'h7FFFFE01, 32'hFF818001};
    vecs[2] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 32'h80008000, 32'h00008000, 32'h7FFF8000, 32'h80010000, 32'h00808000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'h0010, 16'h0005, 1'b1, 1'b1, 32'hFFFF0001, 32'h00000001, 32'hFFFE0001, 32'h0012FE01, 32'h00010004};
    vecs[4] = '{16'h0203, 16'h0405, 16'h0010, 16'h0000, 1'b1, 1'b1, 32'h0008160F, 32'h0008160F, 32'h0008160F, 32'h0008000F, 32'h0008E9F1};
    vecs[5] = '{16'h8000, 16'h8000, 16'h1234, 16'h0001, 1'b0, 1'b0, 32'hC0000000, 32'h40000000, 32'h40000000, 32'h52340000, 32'h40000001};

    rst_n = 1'b0; ce = 1'b0;
    a = 16'h1234; b = 16'h5678; c = '0; d = '0; ast = 1'b0; asb = 1'b0;
    @(negedge clk);
    check("reset_regs", o5, 32'h0);
    check("reset_acc", o6, 32'h0);
    rst_n = 1'b1;

    // Combinational modes across parameterisations
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = vecs[i].a; b = vecs[i].b; c = vecs[i].c; d = vecs[i].d;
      ast = vecs[i].ast; asb = vecs[i].asb;
      #1;
      check($sformatf("v%0d_AsBu", i), o1, vecs[i].e1);
      check($sformatf("v%0d_signed", i), o3, vecs[i].e3);
      check($sformatf("v%0d_unsigned", i), o4, vecs[i].e4);
      check($sformatf("v%0d_addsub_pb8", i), o7, vecs[i].e7);
      check($sformatf("v%0d_pt8_addsub", i), o8, vecs[i].e8);
    end
    check("regs_hold_ce0", o5, 32'h0);
    check("acc_hold_ce0", o6, 32'h0);

    // Registered inputs: one CE edge loads, CE=0 holds
    @(negedge clk);
    a = 16'd3; b = 16'd5; ast = 1'b0; asb = 1'b0;
    #1 check("reg_no_edge_yet", o5, 32'h0);
    ce_edges(1);
    check("reg_loaded", o5, 32'h0000000F);
    a = 16'd7;
    repeat (2) @(negedge clk);
    check("reg_hold", o5, 32'h0000000F);

    // Clear the accumulators (asynchronous, mid-cycle)
    #2 rst_n = 1'b0;
    #1 check("async_rst_acc", o6, 32'h0);
    check("async_rst_regs", o5, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Accumulation: P32 = 0x00010000 per edge
    a = 16'h0100; b = 16'h0100;
    for (int k = 1; k <= 3; k++) begin
      ce_edges(1);
      check($sformatf("acc_step%0d", k), o6, {16'(k), 16'h0000});
    end
    repeat (2) @(negedge clk);
    check("acc_hold", o6, 32'h00030000);

    // Subtract on both halves with P32 = 0x0000000F: bottom borrows without touching top
    a = 16'd3; b = 16'd5; ast = 1'b1; asb = 1'b1;
    ce_edges(1);
    check("acc_sub", o6, 32'h0003FFF1);
    asb = 1'b0;
    ce_edges(1);
    check("acc_wrap", o6, 32'h00030000);

    // Reset mid-cycle with no clock edge
    #2 rst_n = 1'b0;
    #1 check("acc_async_clear", o6, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
